// File: rtl/gf26_inv_arbiter.sv
// Shares one gf26_inverse unit among N_REQ requesters with round-robin arbitration and watchdog abort.
// Latency: winner latched on the request edge, ISSUE next cycle, done one cycle after inv_finish is seen high (or TIMEOUT abort).
// Backpressure: requesters hold req/req_x until their done pulse; losers simply wait, the unit is never overdriven.
// Optional GF26_ZERO_BYPASS_EN: a zero operand is answered immediately with resp_err=1 without starting the unit.
module gf26_inv_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ID_W    = $clog2(N_REQ),
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic [N_REQ-1:0]   req,
  input  logic [6*N_REQ-1:0] req_x,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic [5:0]         resp_z,
  output logic [ID_W-1:0]    resp_id,
  output logic               resp_err,
  output logic               busy,
  output logic               inv_start,
  output logic [5:0]         inv_x,
  input  logic               inv_finish,
  input  logic [5:0]         inv_z
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_CLR, WAIT_SET, RESP} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   id;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   win_id;
  logic [ID_W:0]     scan;
  logic              win_vld;
  logic [N_REQ-1:0]  mask;
  logic [N_REQ-1:0]  elig;
  logic [5:0]        op_x;
  logic [5:0]        win_x;
  logic [7:0]        timer;
  logic              tmo;
  logic              zero_win;

  // the requester just answered is masked for one IDLE cycle to cover its registered req drop
  assign elig  = req & ~mask;
  assign win_x = req_x[int'(win_id)*6 +: 6];
  assign tmo   = (timer == 8'(TIMEOUT));
  assign inv_x = op_x;

`ifdef GF26_ZERO_BYPASS_EN
  assign zero_win = (win_x == 6'd0);
`else
  assign zero_win = 1'b0;
`endif

  // round-robin scan starting at rr_ptr; descending loop so the closest eligible index wins
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    scan    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      scan = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (scan >= (ID_W+1)'(N_REQ)) begin
        scan = scan - (ID_W+1)'(N_REQ);
      end
      if (elig[scan[ID_W-1:0]]) begin
        win_vld = 1'b1;
        win_id  = scan[ID_W-1:0];
      end
    end
  end

  // next-state and decoded outputs; inv_start only in ISSUE so the unit always sees a clean rising edge
  always_comb begin
    state_nxt = state;
    gnt       = '0;
    done      = '0;
    resp_id   = '0;
    busy      = 1'b1;
    inv_start = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (win_vld) begin
          state_nxt = zero_win ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        gnt[id]   = 1'b1;
        inv_start = 1'b1;
        state_nxt = WAIT_CLR;
      end
      WAIT_CLR: begin
        gnt[id] = 1'b1;
        if (tmo) begin
          state_nxt = RESP;
        end else if (!inv_finish) begin
          state_nxt = WAIT_SET;
        end
      end
      WAIT_SET: begin
        gnt[id] = 1'b1;
        if (inv_finish || tmo) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        gnt[id]   = 1'b1;
        done[id]  = 1'b1;
        resp_id   = id;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // transaction datapath: winner capture, watchdog timer, result capture, round-robin update
  always_ff @(posedge clk) begin
    if (!resetN) begin
      id       <= '0;
      op_x     <= '0;
      timer    <= '0;
      rr_ptr   <= '0;
      mask     <= '0;
      resp_z   <= '0;
      resp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mask <= '0;
          if (win_vld) begin
            id    <= win_id;
            op_x  <= win_x;
            timer <= '0;
            if (zero_win) begin
              resp_z   <= '0;
              resp_err <= 1'b1;
            end
          end
        end
        WAIT_CLR: begin
          if (tmo) begin
            resp_z   <= '0;
            resp_err <= 1'b1;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        WAIT_SET: begin
          // a valid result on the same cycle as the timeout is still delivered
          if (inv_finish) begin
            resp_z   <= inv_z;
            resp_err <= 1'b0;
          end else if (tmo) begin
            resp_z   <= '0;
            resp_err <= 1'b1;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        RESP: begin
          rr_ptr <= (id == ID_W'(N_REQ - 1)) ? '0 : id + 1'b1;
          mask   <= {{(N_REQ-1){1'b0}}, 1'b1} << id;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gf26_inv_arbiter.sv
// Bench for gf26_inv_arbiter: behavioural gf26_inverse stub plus scoreboard of expected responses.
// Expected results are pushed in expected service order and popped on each done pulse.
// Field model uses GF(2^6) with polynomial x^6+x+1.
module tb_gf26_inv_arbiter;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;
  localparam int TMO   = 10;

  logic               clk;
  logic               resetN;
  logic [N_REQ-1:0]   req;
  logic [6*N_REQ-1:0] req_x;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   done;
  logic [5:0]         resp_z;
  logic [ID_W-1:0]    resp_id;
  logic               resp_err;
  logic               busy;
  logic               inv_start;
  logic [5:0]         inv_x;
  logic               inv_finish;
  logic [5:0]         inv_z;

  gf26_inv_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .resetN(resetN), .req(req), .req_x(req_x), .gnt(gnt), .done(done),
    .resp_z(resp_z), .resp_id(resp_id), .resp_err(resp_err), .busy(busy),
    .inv_start(inv_start), .inv_x(inv_x), .inv_finish(inv_finish), .inv_z(inv_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
    logic [5:0] p;
    logic [5:0] aa;
    logic       c;
    p  = 6'd0;
    aa = a;
    for (int i = 0; i < 6; i++) begin
      if (b[i]) p = p ^ aa;
      c  = aa[5];
      aa = {aa[4:0], 1'b0};
      if (c) aa = aa ^ 6'h03;
    end
    return p;
  endfunction

  function automatic logic [5:0] gf_inv(input logic [5:0] a);
    logic [5:0] r;
    r = 6'd0;
    for (int v = 1; v < 64; v++) begin
      if (gf_mul(a, 6'(v)) == 6'd1) r = 6'(v);
    end
    return r;
  endfunction

  // inverse unit stub: clears finish on start, raises it with the result lat_cfg+1 edges later
  logic       stuck;
  int         lat_cfg;
  logic       stub_run;
  int         stub_cnt;
  logic [5:0] stub_x;
  always @(posedge clk) begin
    if (!resetN) begin
      inv_finish <= 1'b0;
      inv_z      <= 6'd0;
      stub_run   <= 1'b0;
      stub_cnt   <= 0;
      stub_x     <= 6'd0;
    end else if (inv_start) begin
      inv_finish <= 1'b0;
      stub_x     <= inv_x;
      stub_cnt   <= lat_cfg;
      stub_run   <= 1'b1;
    end else if (stub_run && !stuck) begin
      if (stub_cnt == 0) begin
        inv_finish <= 1'b1;
        inv_z      <= gf_inv(stub_x);
        stub_run   <= 1'b0;
      end else begin
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  typedef struct {
    int         id;
    logic [5:0] x;
    logic [5:0] z;
    logic       err;
    int         starts;
    int         lat;
  } exp_t;

  typedef struct {
    int         id;
    logic [5:0] x;
    logic [5:0] z;
  } vec_t;

  exp_t q[$];
  int   n_chk;
  int   n_fail;
  int   cyc;
  int   starts;
  int   start_cyc;
  int   reissue [N_REQ];
  logic prev_fin;
  logic prev2_fin;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // one cycle: sample at negedge, run monitors and scoreboard, retire requesters on done
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (gnt != '0) chk("gnt_onehot", 32'($onehot(gnt)), 32'd1);
    if (inv_start) begin
      starts++;
      start_cyc = cyc;
      if (q.size() > 0) chk("inv_x", inv_x, q[0].x);
    end
    if (done != '0) begin
      if (q.size() == 0) begin
        chk("unexpected_done", done, 0);
      end else begin
        e = q.pop_front();
        chk("done_onehot", done, 32'd1 << e.id);
        chk("resp_id", resp_id, e.id);
        chk("resp_z", resp_z, e.z);
        chk("resp_err", resp_err, e.err);
        chk("gnt_at_done", gnt, done);
        chk("start_count", starts, e.starts);
        if (!e.err && e.x != 6'd0) chk("z_times_x", gf_mul(resp_z, e.x), 6'd1);
        if (e.lat > 0) chk("abort_latency", cyc - start_cyc, e.lat);
        if (e.starts == 1 && !e.err) chk("done_after_finish", {prev2_fin, prev_fin}, 2'b01);
        if (reissue[e.id] > 0) reissue[e.id]--;
        else req[e.id] = 1'b0;
      end
      starts = 0;
    end
    prev2_fin = prev_fin;
    prev_fin  = inv_finish;
  endtask

  task automatic issue(input int id, input logic [5:0] x, input logic [5:0] z,
                       input logic err, input int st, input int lat);
    exp_t e;
    e.id = id; e.x = x; e.z = z; e.err = err; e.starts = st; e.lat = lat;
    q.push_back(e);
    req_x[id*6 +: 6] = x;
    req[id] = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((q.size() != 0 || req != '0 || busy) && k < 300) begin
      step();
      k++;
    end
    chk({name, "_pending"}, q.size(), 0);
    step();
    chk({name, "_idle"}, busy, 1'b0);
  endtask

  task automatic reset_dut();
    resetN = 1'b0;
    req    = '0;
    q.delete();
    repeat (2) step();
    resetN = 1'b1;
    starts = 0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_resp_z", resp_z, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_inv_start", inv_start, 0);
    chk("rst_inv_x", inv_x, 0);
  endtask

  vec_t vecs [4];
  logic zero_err;
  int   zero_starts;
  logic started;

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; starts = 0; start_cyc = 0;
    prev_fin = 1'b0; prev2_fin = 1'b0;
    stuck = 1'b0; lat_cfg = 2;
    resetN = 1'b0; req = '0; req_x = '0;
    for (int i = 0; i < N_REQ; i++) reissue[i] = 0;

    vecs[0] = '{id: 0, x: 6'h01, z: 6'h01};
    vecs[1] = '{id: 1, x: 6'h02, z: 6'h21};
    vecs[2] = '{id: 2, x: 6'h03, z: 6'h3E};
    vecs[3] = '{id: 3, x: 6'h04, z: 6'h31};

    repeat (3) step();
    chk_reset_vals();
    resetN = 1'b1;
    step();

    // single request on lane 2
    issue(2, 6'h02, 6'h21, 1'b0, 1, 0);
    wait_idle("single");

    // table vectors, one lane at a time, varying stub latency
    for (int i = 0; i < 4; i++) begin
      lat_cfg = i;
      issue(vecs[i].id, vecs[i].x, vecs[i].z, 1'b0, 1, 0);
      wait_idle("table_seq");
    end

    // all four lanes at once after reset: served 0,1,2,3
    lat_cfg = 2;
    reset_dut();
    for (int i = 0; i < 4; i++) issue(vecs[i].id, vecs[i].x, vecs[i].z, 1'b0, 1, 0);
    wait_idle("all_four");

    // fairness: lanes 0 and 3 each reissue once back to back -> 0,3,0,3
    reissue[0] = 1;
    reissue[3] = 1;
    issue(0, 6'h02, 6'h21, 1'b0, 1, 0);
    issue(3, 6'h04, 6'h31, 1'b0, 1, 0);
    q.push_back('{id: 0, x: 6'h02, z: 6'h21, err: 1'b0, starts: 1, lat: 0});
    q.push_back('{id: 3, x: 6'h04, z: 6'h31, err: 1'b0, starts: 1, lat: 0});
    wait_idle("fairness");

    // zero operand on lane 1
`ifdef GF26_ZERO_BYPASS_EN
    zero_err = 1'b1; zero_starts = 0;
`else
    zero_err = 1'b0; zero_starts = 1;
`endif
    issue(1, 6'h00, 6'h00, zero_err, zero_starts, 0);
    wait_idle("zero_op");

    // stuck unit: watchdog aborts TIMEOUT+2 cycles after the start cycle
    stuck = 1'b1;
    issue(3, 6'h07, 6'h00, 1'b1, 1, TMO + 2);
    wait_idle("stuck");
    stuck = 1'b0;
    step();

    // reset pulse while waiting for finish abandons the transaction
    lat_cfg = 6;
    issue(1, 6'h05, gf_inv(6'h05), 1'b0, 1, 0);
    started = 1'b0;
    for (int k = 0; k < 50 && !started; k++) begin
      step();
      started = inv_start;
    end
    chk("mid_start_seen", started, 1'b1);
    repeat (3) step();
    chk("mid_busy", busy, 1'b1);
    chk("mid_gnt", gnt, 4'b0010);
    resetN = 1'b0;
    req    = '0;
    q.delete();
    step();
    chk_reset_vals();
    resetN = 1'b1;
    starts = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("post_reset_no_done", done, 0);
    end

    // fresh request completes normally
    lat_cfg = 1;
    issue(1, 6'h03, 6'h3E, 1'b0, 1, 0);
    wait_idle("fresh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
